// File: rtl/sensor_tx_scheduler.sv
// Shares one byte-wide UART transmitter between the distance and DHT sensors:
// latches readings, converts them to decimal ASCII and streams them as text frames.
module sensor_tx_scheduler #(
    parameter int GAP_CYCLES = 0,
    parameter bit RR_EN      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  i_dist_data,
    input  logic        dist_done,
    input  logic [31:0] i_dht_data,
    input  logic        dht_done,
    input  logic        tx_busy,
    input  logic        tx_done,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_frame_src,
    output logic [7:0]  o_drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CONV, S_SEND_START, S_SEND_WAIT, S_GAP, S_DONE
    } state_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state_q;
    logic             dist_pend_q, dht_pend_q;
    logic [9:0]       dist_buf_q;
    logic [7:0]       dht_hum_q, dht_tmp_q;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic [8:0]       drop_sum;
    logic             last_grant_q, src_q;
    logic [9:0]       work_a_q;
    logic [7:0]       work_b_q;
    logic [25:0]      dd_q, dd_nxt;
    logic [3:0]       conv_cnt_q;
    logic             pass_q;
    logic [15:0]      dig_a_q;
    logic [11:0]      dig_b_q;
    logic [3:0]       byte_idx_q, last_idx;
    logic [GAP_W-1:0] gap_cnt_q;
    logic             tx_start_q, frame_done_q, frame_src_q;
    logic [7:0]       tx_data_q, byte_nxt;
    logic             grant_v, grant_src, dist_drop, dht_drop;
    logic             unused_dht_dec;

    // Decimal fractions of the DHT reading are never transmitted.
    assign unused_dht_dec = ^{i_dht_data[23:16], i_dht_data[7:0]};

    assign tx_start     = tx_start_q;
    assign tx_data      = tx_data_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_frame_done = frame_done_q;
    assign o_frame_src  = frame_src_q;
    assign o_drop_cnt   = drop_cnt_q;

    function automatic logic [25:0] dd_step(input logic [25:0] v);
        logic [25:0] a;
        a = v;
        for (int i = 0; i < 4; i++) begin
            if (a[10+4*i +: 4] >= 4'd5) a[10+4*i +: 4] = a[10+4*i +: 4] + 4'd3;
        end
        return {a[24:0], 1'b0};
    endfunction

    function automatic logic [7:0] asc(input logic [3:0] d);
        return {4'h3, d};
    endfunction

    always_comb begin
        grant_v   = (state_q == S_IDLE) && (dist_pend_q || dht_pend_q);
        grant_src = dht_pend_q;
        if (dist_pend_q && dht_pend_q) grant_src = RR_EN ? ~last_grant_q : 1'b0;
    end

    // A pulse landing on the cycle its own source is granted refills the
    // buffer without counting as a drop.
    always_comb begin
        dist_drop  = dist_done && dist_pend_q && !(grant_v && !grant_src);
        dht_drop   = dht_done && dht_pend_q && !(grant_v && grant_src);
        drop_sum   = {1'b0, drop_cnt_q} + {8'd0, dist_drop} + {8'd0, dht_drop};
        drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dist_pend_q <= 1'b0;
            dht_pend_q  <= 1'b0;
            dist_buf_q  <= '0;
            dht_hum_q   <= '0;
            dht_tmp_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            if (dist_done) begin
                dist_buf_q  <= i_dist_data;
                dist_pend_q <= 1'b1;
            end else if (grant_v && !grant_src) begin
                dist_pend_q <= 1'b0;
            end
            if (dht_done) begin
                dht_hum_q  <= i_dht_data[31:24];
                dht_tmp_q  <= i_dht_data[15:8];
                dht_pend_q <= 1'b1;
            end else if (grant_v && grant_src) begin
                dht_pend_q <= 1'b0;
            end
        end
    end

    assign dd_nxt   = dd_step(dd_q);
    assign last_idx = src_q ? 4'd12 : 4'd7;

    always_comb begin
        byte_nxt = 8'h00;
        if (!src_q) begin
            case (byte_idx_q)
                4'd0: byte_nxt = 8'h44;
                4'd1: byte_nxt = 8'h3A;
                4'd2: byte_nxt = asc(dig_a_q[15:12]);
                4'd3: byte_nxt = asc(dig_a_q[11:8]);
                4'd4: byte_nxt = asc(dig_a_q[7:4]);
                4'd5: byte_nxt = asc(dig_a_q[3:0]);
                4'd6: byte_nxt = 8'h0D;
                4'd7: byte_nxt = 8'h0A;
                default: byte_nxt = 8'h00;
            endcase
        end else begin
            case (byte_idx_q)
                4'd0:  byte_nxt = 8'h54;
                4'd1:  byte_nxt = 8'h3A;
                4'd2:  byte_nxt = asc(dig_a_q[11:8]);
                4'd3:  byte_nxt = asc(dig_a_q[7:4]);
                4'd4:  byte_nxt = asc(dig_a_q[3:0]);
                4'd5:  byte_nxt = 8'h20;
                4'd6:  byte_nxt = 8'h48;
                4'd7:  byte_nxt = 8'h3A;
                4'd8:  byte_nxt = asc(dig_b_q[11:8]);
                4'd9:  byte_nxt = asc(dig_b_q[7:4]);
                4'd10: byte_nxt = asc(dig_b_q[3:0]);
                4'd11: byte_nxt = 8'h0D;
                4'd12: byte_nxt = 8'h0A;
                default: byte_nxt = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            src_q        <= 1'b0;
            work_a_q     <= '0;
            work_b_q     <= '0;
            dd_q         <= '0;
            conv_cnt_q   <= '0;
            pass_q       <= 1'b0;
            dig_a_q      <= '0;
            dig_b_q      <= '0;
            byte_idx_q   <= '0;
            gap_cnt_q    <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_src_q  <= 1'b0;
        end else begin
            tx_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (grant_v) begin
                    src_q    <= grant_src;
                    work_a_q <= grant_src ? {2'b00, dht_tmp_q} : dist_buf_q;
                    work_b_q <= dht_hum_q;
                    state_q  <= S_LOAD;
                end
                S_LOAD: begin
                    dd_q       <= {16'd0, work_a_q};
                    conv_cnt_q <= '0;
                    pass_q     <= 1'b0;
                    state_q    <= S_CONV;
                end
                S_CONV: begin
                    conv_cnt_q <= conv_cnt_q + 4'd1;
                    if (conv_cnt_q == 4'd9) begin
                        if (!pass_q) dig_a_q <= dd_nxt[25:10];
                        else         dig_b_q <= dd_nxt[21:10];
                        // DHT runs a second pass for humidity after temperature.
                        if (src_q && !pass_q) begin
                            pass_q     <= 1'b1;
                            conv_cnt_q <= '0;
                            dd_q       <= {18'd0, work_b_q};
                        end else begin
                            byte_idx_q <= '0;
                            state_q    <= S_SEND_START;
                        end
                    end else begin
                        dd_q <= dd_nxt;
                    end
                end
                S_SEND_START: if (!tx_busy) begin
                    tx_start_q <= 1'b1;
                    tx_data_q  <= byte_nxt;
                    state_q    <= S_SEND_WAIT;
                end
                S_SEND_WAIT: if (tx_done) begin
                    if (byte_idx_q == last_idx) begin
                        frame_done_q <= 1'b1;
                        frame_src_q  <= src_q;
                        state_q      <= S_DONE;
                    end else begin
                        byte_idx_q <= byte_idx_q + 4'd1;
                        gap_cnt_q  <= '0;
                        state_q    <= (GAP_CYCLES > 0) ? S_GAP : S_SEND_START;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) state_q <= S_SEND_START;
                    else gap_cnt_q <= gap_cnt_q + 1'b1;
                end
                S_DONE: begin
                    last_grant_q <= src_q;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_tx_scheduler.sv
// Bench for sensor_tx_scheduler: a UART model answers each start, and a byte/frame
// scoreboard filled at stimulus time is drained as the DUT transmits.
module tb_sensor_tx_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  i_dist_data;
    logic        dist_done;
    logic [31:0] i_dht_data;
    logic        dht_done;
    logic        tx_busy;
    logic        tx_done = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        o_busy, o_frame_done, o_frame_src;
    logic [7:0]  o_drop_cnt;
    logic        hold_busy;
    logic        model_busy = 1'b0;
    int          model_cnt = 0;

    logic [7:0]  exp_q[$];
    bit          exp_src_q[$];
    int          vecs = 0;
    int          errs = 0;
    logic [7:0]  cur_byte, e_byte;
    bit          e_src;
    bit          in_flight = 1'b0;

    sensor_tx_scheduler dut (
        .clk(clk), .rst(rst),
        .i_dist_data(i_dist_data), .dist_done(dist_done),
        .i_dht_data(i_dht_data), .dht_done(dht_done),
        .tx_busy(tx_busy), .tx_done(tx_done),
        .tx_start(tx_start), .tx_data(tx_data),
        .o_busy(o_busy), .o_frame_done(o_frame_done),
        .o_frame_src(o_frame_src), .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;
    assign tx_busy = model_busy | hold_busy;

    // UART model: busy for 50 cycles after each start, then a tx_done pulse.
    initial forever begin
        @(posedge clk);
        if (!rst) begin
            model_busy <= 1'b0;
            model_cnt  <= 0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (model_busy) begin
                if (model_cnt == 1) begin
                    model_busy <= 1'b0;
                    tx_done    <= 1'b1;
                end
                model_cnt <= model_cnt - 1;
            end else if (tx_start) begin
                model_busy <= 1'b1;
                model_cnt  <= 50;
            end
        end
    end

    // Scoreboard monitor.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            in_flight = 1'b0;
        end else begin
            if (tx_start) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL tx_byte: got %02h, no byte expected", tx_data);
                end else begin
                    e_byte = exp_q.pop_front();
                    if (tx_data !== e_byte) begin
                        errs++;
                        $display("FAIL tx_byte: got %02h expected %02h", tx_data, e_byte);
                    end
                end
                cur_byte  = tx_data;
                in_flight = 1'b1;
            end
            if (tx_done && in_flight) begin
                vecs++;
                if (tx_data !== cur_byte) begin
                    errs++;
                    $display("FAIL tx_data_stable: got %02h expected %02h", tx_data, cur_byte);
                end
                in_flight = 1'b0;
            end
            if (o_frame_done) begin
                vecs++;
                if (exp_src_q.size() == 0) begin
                    errs++;
                    $display("FAIL frame_done: got src %0d, no frame expected", o_frame_src);
                end else begin
                    e_src = exp_src_q.pop_front();
                    if (o_frame_src !== e_src) begin
                        errs++;
                        $display("FAIL frame_src: got %0d expected %0d", o_frame_src, e_src);
                    end
                end
            end
        end
    end

    function automatic logic [7:0] dg(input int v);
        return 8'(48 + (v % 10));
    endfunction

    function automatic void push_dist(input int v);
        exp_q.push_back(8'h44); exp_q.push_back(8'h3A);
        exp_q.push_back(dg(v / 1000)); exp_q.push_back(dg(v / 100));
        exp_q.push_back(dg(v / 10));   exp_q.push_back(dg(v));
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        exp_src_q.push_back(1'b0);
    endfunction

    function automatic void push_dht(input int t, input int h);
        exp_q.push_back(8'h54); exp_q.push_back(8'h3A);
        exp_q.push_back(dg(t / 100)); exp_q.push_back(dg(t / 10)); exp_q.push_back(dg(t));
        exp_q.push_back(8'h20); exp_q.push_back(8'h48); exp_q.push_back(8'h3A);
        exp_q.push_back(dg(h / 100)); exp_q.push_back(dg(h / 10)); exp_q.push_back(dg(h));
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        exp_src_q.push_back(1'b1);
    endfunction

    task automatic pulse(input bit d, input logic [9:0] dv, input bit h, input logic [31:0] hv);
        @(negedge clk);
        i_dist_data = dv; i_dht_data = hv; dist_done = d; dht_done = h;
        @(negedge clk);
        dist_done = 1'b0; dht_done = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || exp_src_q.size() != 0 || o_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        vecs++;
        if (n >= budget) begin
            errs++;
            $display("FAIL %s drain: timeout, got %0d bytes pending expected 0", tag, exp_q.size());
        end
    endtask

    // Cycles from the grant (o_busy rising) to the first tx_start.
    task automatic grant_latency(output int lat);
        int n = 0;
        while (!o_busy && n < 10) begin @(negedge clk); n++; end
        lat = 0;
        while (!tx_start && lat < 300) begin @(negedge clk); lat++; end
    endtask

    task automatic test_reset();
        int starts = 0;
        #3 rst = 1'b0;
        #1;
        vecs += 6;
        if (tx_start !== 1'b0)     begin errs++; $display("FAIL rst_tx_start: got %b expected 0", tx_start); end
        if (tx_data !== 8'h00)     begin errs++; $display("FAIL rst_tx_data: got %02h expected 00", tx_data); end
        if (o_busy !== 1'b0)       begin errs++; $display("FAIL rst_busy: got %b expected 0", o_busy); end
        if (o_frame_done !== 1'b0) begin errs++; $display("FAIL rst_frame_done: got %b expected 0", o_frame_done); end
        if (o_frame_src !== 1'b0)  begin errs++; $display("FAIL rst_frame_src: got %b expected 0", o_frame_src); end
        if (o_drop_cnt !== 8'h00)  begin errs++; $display("FAIL rst_drop_cnt: got %0d expected 0", o_drop_cnt); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) begin @(negedge clk); if (tx_start || o_busy) starts++; end
        vecs++;
        if (starts != 0) begin errs++; $display("FAIL idle_after_reset: got %0d active cycles expected 0", starts); end
    endtask

    task automatic test_dist();
        int lat;
        push_dist(123);
        pulse(1'b1, 10'd123, 1'b0, 32'h0);
        grant_latency(lat);
        vecs++;
        if (lat != 12) begin errs++; $display("FAIL dist_latency: got %0d expected 12", lat); end
        wait_drain(1500, "dist");
    endtask

    task automatic test_dht();
        int lat;
        push_dht(198, 170);
        pulse(1'b0, 10'd0, 1'b1, 32'haa_0f_c6_00);
        grant_latency(lat);
        vecs++;
        if (lat != 22) begin errs++; $display("FAIL dht_latency: got %0d expected 22", lat); end
        wait_drain(1500, "dht");
    endtask

    task automatic test_simultaneous();
        push_dist(1023);
        push_dht(0, 0);
        pulse(1'b1, 10'd1023, 1'b1, 32'h00_00_00_00);
        wait_drain(3000, "simul1");
        push_dist(42);
        push_dht(25, 60);
        pulse(1'b1, 10'd42, 1'b1, {8'd60, 8'd0, 8'd25, 8'd0});
        wait_drain(3000, "simul2");
        vecs++;
        if (o_drop_cnt !== 8'd0) begin errs++; $display("FAIL simul_drop_cnt: got %0d expected 0", o_drop_cnt); end
    endtask

    task automatic test_drop();
        push_dht(30, 45);
        pulse(1'b0, 10'd0, 1'b1, {8'd45, 8'd0, 8'd30, 8'd0});
        repeat (100) @(negedge clk);
        pulse(1'b1, 10'd5, 1'b0, 32'h0);
        vecs++;
        if (o_drop_cnt !== 8'd0) begin errs++; $display("FAIL drop_first: got %0d expected 0", o_drop_cnt); end
        repeat (5) @(negedge clk);
        pulse(1'b1, 10'd7, 1'b0, 32'h0);
        vecs++;
        if (o_drop_cnt !== 8'd1) begin errs++; $display("FAIL drop_second: got %0d expected 1", o_drop_cnt); end
        push_dist(7);
        wait_drain(3000, "drop");
    endtask

    task automatic test_busy_hold();
        int starts = 0;
        int n = 0;
        @(negedge clk);
        hold_busy = 1'b1;
        push_dist(456);
        pulse(1'b1, 10'd456, 1'b0, 32'h0);
        repeat (200) begin @(negedge clk); if (tx_start) starts++; end
        vecs += 2;
        if (starts != 0) begin errs++; $display("FAIL busy_hold_start: got %0d starts expected 0", starts); end
        if (o_busy !== 1'b1) begin errs++; $display("FAIL busy_hold_busy: got %b expected 1", o_busy); end
        hold_busy = 1'b0;
        while (!tx_start && n < 10) begin @(negedge clk); n++; end
        vecs++;
        if (n != 1) begin errs++; $display("FAIL busy_release_lat: got %0d expected 1", n); end
        @(negedge clk);
        vecs++;
        if (tx_start !== 1'b0) begin errs++; $display("FAIL start_width: got %b expected 0", tx_start); end
        wait_drain(1500, "busy_hold");
    endtask

    task automatic test_reset_mid();
        int starts = 0;
        int n = 0;
        int act = 0;
        push_dht(12, 34);
        pulse(1'b0, 10'd0, 1'b1, {8'd34, 8'd0, 8'd12, 8'd0});
        while (starts < 4 && n < 1500) begin
            @(negedge clk);
            n++;
            if (tx_start) starts++;
        end
        vecs++;
        if (starts != 4) begin errs++; $display("FAIL mid_reach_byte4: got %0d starts expected 4", starts); end
        #1 rst = 1'b0;
        #1;
        vecs += 3;
        if (tx_start !== 1'b0)    begin errs++; $display("FAIL mid_rst_tx_start: got %b expected 0", tx_start); end
        if (o_busy !== 1'b0)      begin errs++; $display("FAIL mid_rst_busy: got %b expected 0", o_busy); end
        if (o_drop_cnt !== 8'h00) begin errs++; $display("FAIL mid_rst_drop_cnt: got %0d expected 0", o_drop_cnt); end
        exp_q.delete();
        exp_src_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (100) begin @(negedge clk); if (tx_start || o_busy) act++; end
        vecs++;
        if (act != 0) begin errs++; $display("FAIL mid_idle_after: got %0d active cycles expected 0", act); end
        push_dist(9);
        pulse(1'b1, 10'd9, 1'b0, 32'h0);
        wait_drain(1500, "after_reset");
    endtask

    initial begin
        i_dist_data = '0;
        i_dht_data  = '0;
        dist_done   = 1'b0;
        dht_done    = 1'b0;
        hold_busy   = 1'b0;
        test_reset();
        test_dist();
        test_dht();
        test_simultaneous();
        test_drop();
        test_busy_hold();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/sensor_tx_scheduler.md
Name: sensor_tx_scheduler

Overview:
Shares one byte-wide UART transmitter between the distance sensor and the DHT temperature/humidity sensor. Each completed reading is latched and converted to decimal ASCII. The block then sends it as a text frame, one byte per UART handshake. It sits between the sensor controllers (dist_done/dht_done pulses) and the uart_tx core, and its frame output goes to the PC terminal.

Parameters:
GAP_CYCLES, 0, idle clk cycles inserted after each tx_done before the next tx_start (0 = back-to-back)
RR_EN, 1, 1 = round-robin between sources; 0 = distance always wins ties

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
i_dist_data  in  10  distance in cm, valid when dist_done=1
dist_done  in  1  1-cycle pulse, new distance reading
i_dht_data  in  32  [31:24] humidity int, [23:16] humidity dec, [15:8] temp int, [7:0] temp dec; valid when dht_done=1
dht_done  in  1  1-cycle pulse, new DHT reading
tx_busy  in  1  uart_tx is transmitting
tx_done  in  1  1-cycle pulse, uart_tx finished the current byte
tx_start  out  1  1-cycle pulse, start sending tx_data
tx_data  out  8  byte to send
o_busy  out  1  high whenever the state is not IDLE
o_frame_done  out  1  1-cycle pulse after the last byte of a frame completes
o_frame_src  out  1  source of the frame just finished: 0 = dist, 1 = dht; valid with o_frame_done
o_drop_cnt  out  8  saturating count of readings overwritten before they were sent

Behaviour:
- Reset (rst=0, async): every output is 0, pending flags are cleared, last_grant is set to DHT, state goes to IDLE. Reset mid-frame abandons the frame, and tx_start drops at once.
- Capture, every cycle in every state:
  - dist_done=1 copies i_dist_data into dist_buf and sets dist_pend.
  - dht_done=1 copies i_dht_data into dht_buf and sets dht_pend.
  - If the flag is already set when a new pulse arrives, the buffer is overwritten (newest wins) and o_drop_cnt increments (saturates at 255).
  - Both pulses in the same cycle: both are captured.
- Arbitration in IDLE, when any pending flag is set:
  - Only one flag set: grant that source.
  - Both set, RR_EN=1: grant the source that is not last_grant. With RR_EN=0, grant distance.
  - The grant copies the buffer into a working register and clears the pending flag; then LOAD. If a capture arrives in the grant cycle, the capture wins and the flag stays set (no drop counted).
- CONV: sequential double-dabble, one shift per cycle, 10 shifts per value, result 4 BCD digits.
  - Distance: one conversion of i_dist_data → 4 digits.
  - DHT: temp int (zero-extended to 10 bits) is converted first, then humidity int; the low 3 digits of each are used.
  - Decimal bytes [23:16] and [7:0] are not transmitted.
- Frame formats (ASCII, leading zeros kept):
  - Distance, 8 bytes: 'D' ':' d3 d2 d1 d0 CR LF.
  - DHT, 13 bytes: 'T' ':' t2 t1 t0 ' ' 'H' ':' h2 h1 h0 CR LF.
- States: IDLE → LOAD → CONV → SEND_START → SEND_WAIT → (GAP) → SEND_START … → DONE → IDLE.
  - SEND_START: tx_start=1 for exactly 1 cycle, only when tx_busy=0; otherwise wait in place.
  - SEND_WAIT: tx_data held stable from the tx_start cycle until tx_done.
  - On tx_done: go to GAP if GAP_CYCLES>0, else straight to the next byte. After the last byte, go to DONE.
  - DONE: o_frame_done=1 and o_frame_src valid for 1 cycle; last_grant is updated; then IDLE.
  - A tx_done outside SEND_WAIT is ignored.
- Timing from grant (IDLE→LOAD edge) to the first tx_start, with tx_busy=0:
  - Distance: 12 cycles (LOAD 1, CONV 10, SEND_START 1).
  - DHT: 22 cycles (LOAD 1, CONV 20, SEND_START 1).
- One frame is in flight at a time. New readings only update buffers and pending flags; they never corrupt the frame being sent.

Test Plan:
- dist_done with i_dist_data=10'd123, tx model answers tx_done 50 cycles after each start → bytes 44 3A 30 31 32 33 0D 0A, then o_frame_done with o_frame_src=0. Check the first tx_start comes 12 cycles after the grant.
- dht_done with i_dht_data=32'haa_0f_c6_00 → bytes 54 3A 31 39 38 20 48 3A 31 37 30 0D 0A, then o_frame_done with o_frame_src=1.
- dist_done and dht_done in the same cycle (dist=1023, dht=32'h00_00_00_00), RR_EN=1:
  - First frame: "D:1023\r\n".
  - Second frame: "T:000 H:000\r\n".
  - Repeat the simultaneous pulse → distance frame first again (last_grant=DHT).
- Two dist_done pulses (5 then 7) while a DHT frame is sending → o_drop_cnt=1, and the next distance frame is "D:0007\r\n".
- Hold tx_busy=1 for 200 cycles at the first byte → no tx_start until tx_busy falls; then exactly one 1-cycle tx_start, with tx_data stable until tx_done.
- Assert rst=0 during byte 4 of a DHT frame → tx_start, o_busy and o_drop_cnt are 0 immediately. After release, no frame starts until a new done pulse arrives.
